// File: rtl/coin_credit_fsm.sv
// Coin-credit accumulator and vend controller: sums coin pulses, vends at PRICE,
// refunds on cancel, and holds the vend/refund status for HOLD_CYCLES cycles.
module coin_credit_fsm #(
  parameter int unsigned                  NUM_COIN    = 2,
  parameter int unsigned                  CNT_W       = 8,
  parameter logic [NUM_COIN*CNT_W-1:0]    COIN_VAL    = {8'd10, 8'd5},
  parameter int unsigned                  PRICE       = 25,
  parameter int unsigned                  HOLD_CYCLES = 100_000_000,
  parameter int unsigned                  HOLD_W      = 27
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_COIN-1:0] coin,
  input  logic                cancel,
  output logic [CNT_W-1:0]    credit,
  output logic                vend,
  output logic [CNT_W-1:0]    change,
  output logic [1:0]          status,
  output logic                busy
);

  localparam int unsigned SUM_W = CNT_W + 1;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_EXACT  = 2'b01;
  localparam logic [1:0] ST_CHANGE = 2'b11;
  localparam logic [1:0] ST_REFUND = 2'b10;

  typedef enum logic {COLLECT, HOLD} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   credit_q, credit_d;
  logic [CNT_W-1:0]   change_q, change_d;
  logic [1:0]         status_q, status_d;
  logic               vend_q, vend_d;
  logic               busy_q, busy_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

  logic [CNT_W-1:0]   coin_val;
  logic [SUM_W-1:0]   sum;

  // Lowest-index asserted channel wins; scanning downward lets it overwrite the rest
  always_comb begin
    coin_val = '0;
    for (int i = int'(NUM_COIN) - 1; i >= 0; i--) begin
      if (coin[i]) coin_val = COIN_VAL[i*CNT_W +: CNT_W];
    end
  end

  assign sum = {1'b0, credit_q} + {1'b0, coin_val};

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    change_d   = change_q;
    status_d   = status_q;
    busy_d     = busy_q;
    hold_cnt_d = hold_cnt_q;
    vend_d     = 1'b0;
    case (state_q)
      COLLECT: begin
        if (cancel && (sum != '0)) begin
          change_d   = CNT_W'(sum);
          status_d   = ST_REFUND;
          credit_d   = '0;
          hold_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = HOLD;
        end else if (sum >= SUM_W'(PRICE)) begin
          vend_d     = 1'b1;
          change_d   = CNT_W'(sum - SUM_W'(PRICE));
          status_d   = (sum == SUM_W'(PRICE)) ? ST_EXACT : ST_CHANGE;
          credit_d   = '0;
          hold_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = HOLD;
        end else begin
          credit_d   = CNT_W'(sum);
        end
      end
      HOLD: begin
        // Inputs are ignored here; only the hold timer advances
        if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          status_d   = ST_IDLE;
          change_d   = '0;
          hold_cnt_d = '0;
          busy_d     = 1'b0;
          state_d    = COLLECT;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      credit_q   <= '0;
      change_q   <= '0;
      status_q   <= ST_IDLE;
      vend_q     <= 1'b0;
      busy_q     <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      change_q   <= change_d;
      status_q   <= status_d;
      vend_q     <= vend_d;
      busy_q     <= busy_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign credit = credit_q;
  assign change = change_q;
  assign status = status_q;
  assign vend   = vend_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_coin_credit_fsm.sv
// Bench for coin_credit_fsm: a default-coin instance and a 3-channel instance,
// checked with directed scenarios and random traffic against a transaction model.
module tb_coin_credit_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] coin_a = '0;
  logic       cancel_a = 1'b0;
  logic [2:0] coin_b = '0;
  logic       cancel_b = 1'b0;

  logic [7:0] credit_a, change_a, credit_b, change_b;
  logic [1:0] status_a, status_b;
  logic       vend_a, busy_a, vend_b, busy_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  coin_credit_fsm #(
    .NUM_COIN(2), .CNT_W(8), .COIN_VAL({8'd10, 8'd5}), .PRICE(25),
    .HOLD_CYCLES(10), .HOLD_W(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .coin(coin_a), .cancel(cancel_a),
    .credit(credit_a), .vend(vend_a), .change(change_a), .status(status_a), .busy(busy_a)
  );

  coin_credit_fsm #(
    .NUM_COIN(3), .CNT_W(8), .COIN_VAL({8'd20, 8'd10, 8'd1}), .PRICE(7),
    .HOLD_CYCLES(5), .HOLD_W(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .coin(coin_b), .cancel(cancel_b),
    .credit(credit_b), .vend(vend_b), .change(change_b), .status(status_b), .busy(busy_b)
  );

  // Transaction-level model: credit as an integer, hold as a countdown of busy cycles left
  typedef struct {
    int credit;
    bit vend;
    int change;
    int status;
    bit busy;
    int hold_left;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t step(mdl_t m, int v0, int v1, int v2, int price, int hold,
                                logic [2:0] c, logic x);
    int add, sum;
    m.vend = 1'b0;
    if (m.hold_left > 0) begin
      m.hold_left--;
      if (m.hold_left == 0) begin
        m.busy = 1'b0; m.status = 0; m.change = 0;
      end
      return m;
    end
    add = c[0] ? v0 : c[1] ? v1 : c[2] ? v2 : 0;
    sum = m.credit + add;
    if (x && sum > 0) begin
      m.change = sum; m.status = 2; m.credit = 0; m.busy = 1'b1; m.hold_left = hold;
    end else if (sum >= price) begin
      m.vend = 1'b1; m.change = sum - price; m.status = (sum == price) ? 1 : 3;
      m.credit = 0; m.busy = 1'b1; m.hold_left = hold;
    end else begin
      m.credit = sum;
    end
    return m;
  endfunction

  // One clock: drive both DUTs, advance both models, settle 1 time unit past the edge
  task automatic tick(input logic [1:0] ca, input logic xa, input logic [2:0] cb, input logic xb);
    coin_a = ca; cancel_a = xa; coin_b = cb; cancel_b = xb;
    @(posedge clk);
    ma = step(ma, 5, 10, 0, 25, 10, {1'b0, ca}, xa);
    mb = step(mb, 1, 10, 20, 7, 5, cb, xb);
    #1;
    coin_a = '0; cancel_a = 1'b0; coin_b = '0; cancel_b = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ma = '{default: 0};
    mb = '{default: 0};
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({credit_a, vend_a, change_a, status_a, busy_a} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_a: got credit=%0d vend=%0b change=%0d status=%b busy=%0b, want all 0",
               credit_a, vend_a, change_a, status_a, busy_a);
    end
    n_cmp++;
    if ({credit_b, vend_b, change_b, status_b, busy_b} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_b: got credit=%0d vend=%0b change=%0d status=%b busy=%0b, want all 0",
               credit_b, vend_b, change_b, status_b, busy_b);
    end
    do_reset();
  endtask

  task automatic test_exact_price();
    int busy_cnt = 1;
    int extra_vend = 0;
    do_reset();
    tick(2'b01, 0, 0, 0);
    n_cmp++;
    if (credit_a !== 8'd5) begin n_err++; $display("FAIL exact_credit1: got %0d want 5", credit_a); end
    tick(2'b10, 0, 0, 0);
    n_cmp++;
    if (credit_a !== 8'd15) begin n_err++; $display("FAIL exact_credit2: got %0d want 15", credit_a); end
    tick(2'b10, 0, 0, 0);
    n_cmp++;
    if ({vend_a, status_a, change_a, credit_a, busy_a} !== {1'b1, 2'b01, 8'd0, 8'd0, 1'b1}) begin
      n_err++;
      $display("FAIL exact_vend: got vend=%0b status=%b change=%0d credit=%0d busy=%0b want 1 01 0 0 1",
               vend_a, status_a, change_a, credit_a, busy_a);
    end
    for (int g = 0; g < 40 && busy_a; g++) begin
      tick(0, 0, 0, 0);
      if (vend_a) extra_vend++;
      if (busy_a) busy_cnt++;
    end
    n_cmp++;
    if (busy_cnt != 10 || extra_vend != 0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL exact_hold: got busy_cycles=%0d extra_vend=%0d busy=%0b want 10 0 0",
               busy_cnt, extra_vend, busy_a);
    end
    n_cmp++;
    if (status_a !== 2'b00) begin n_err++; $display("FAIL exact_status_clr: got %b want 00", status_a); end
  endtask

  task automatic test_overpay();
    do_reset();
    tick(2'b10, 0, 0, 0);
    tick(2'b10, 0, 0, 0);
    n_cmp++;
    if (credit_a !== 8'd20) begin n_err++; $display("FAIL over_credit: got %0d want 20", credit_a); end
    tick(2'b10, 0, 0, 0);
    n_cmp++;
    if ({vend_a, status_a, change_a, credit_a} !== {1'b1, 2'b11, 8'd5, 8'd0}) begin
      n_err++;
      $display("FAIL over_vend: got vend=%0b status=%b change=%0d credit=%0d want 1 11 5 0",
               vend_a, status_a, change_a, credit_a);
    end
    for (int g = 0; g < 40 && busy_a; g++) tick(0, 0, 0, 0);
    n_cmp++;
    if ({busy_a, status_a, change_a} !== 11'h0) begin
      n_err++;
      $display("FAIL over_clear: got busy=%0b status=%b change=%0d want 0 00 0", busy_a, status_a, change_a);
    end
  endtask

  task automatic test_refund();
    do_reset();
    tick(2'b10, 0, 0, 0);
    tick(2'b01, 0, 0, 0);
    tick(2'b01, 1, 0, 0);
    n_cmp++;
    if ({vend_a, status_a, change_a, credit_a, busy_a} !== {1'b0, 2'b10, 8'd20, 8'd0, 1'b1}) begin
      n_err++;
      $display("FAIL refund: got vend=%0b status=%b change=%0d credit=%0d busy=%0b want 0 10 20 0 1",
               vend_a, status_a, change_a, credit_a, busy_a);
    end
    for (int g = 0; g < 40 && busy_a; g++) tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    n_cmp++;
    if ({busy_a, status_a, change_a, credit_a, vend_a} !== 20'h0) begin
      n_err++;
      $display("FAIL cancel_zero: got busy=%0b status=%b change=%0d credit=%0d vend=%0b want all 0",
               busy_a, status_a, change_a, credit_a, vend_a);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    tick(2'b11, 0, 0, 0);
    n_cmp++;
    if (credit_a !== 8'd5) begin n_err++; $display("FAIL simul_coins: got credit %0d want 5", credit_a); end
  endtask

  task automatic test_lockout_reset();
    do_reset();
    tick(2'b10, 0, 0, 0);
    tick(2'b10, 0, 0, 0);
    tick(2'b10, 0, 0, 0);
    for (int g = 0; g < 40 && busy_a; g++) tick(2'b11, 1, 0, 0);
    n_cmp++;
    if ({busy_a, credit_a, status_a, change_a} !== 19'h0) begin
      n_err++;
      $display("FAIL lockout: got busy=%0b credit=%0d status=%b change=%0d want 0 0 00 0",
               busy_a, credit_a, status_a, change_a);
    end
    tick(2'b01, 0, 0, 0);
    n_cmp++;
    if (credit_a !== 8'd5) begin n_err++; $display("FAIL first_after_hold: got credit %0d want 5", credit_a); end
    tick(2'b10, 0, 0, 0);
    tick(2'b10, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    n_cmp++;
    if ({busy_a, status_a} !== 3'b101) begin
      n_err++;
      $display("FAIL pre_reset_hold: got busy=%0b status=%b want 1 01", busy_a, status_a);
    end
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({credit_a, vend_a, change_a, status_a, busy_a} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_mid_hold: got credit=%0d vend=%0b change=%0d status=%b busy=%0b want all 0",
               credit_a, vend_a, change_a, status_a, busy_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ma = '{default: 0};
    mb = '{default: 0};
    tick(2'b01, 0, 0, 0);
    n_cmp++;
    if ({credit_a, busy_a} !== {8'd5, 1'b0}) begin
      n_err++;
      $display("FAIL restart_collect: got credit=%0d busy=%0b want 5 0", credit_a, busy_a);
    end
  endtask

  task automatic test_general();
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      tick(0, 0, 3'b001, 0);
      if (i < 7) begin
        n_cmp++;
        if (credit_b !== 8'(i)) begin n_err++; $display("FAIL gen_credit%0d: got %0d want %0d", i, credit_b, i); end
      end
    end
    n_cmp++;
    if ({vend_b, status_b, change_b, credit_b} !== {1'b1, 2'b01, 8'd0, 8'd0}) begin
      n_err++;
      $display("FAIL gen_exact: got vend=%0b status=%b change=%0d credit=%0d want 1 01 0 0",
               vend_b, status_b, change_b, credit_b);
    end
    for (int g = 0; g < 40 && busy_b; g++) tick(0, 0, 0, 0);
    tick(0, 0, 3'b100, 0);
    n_cmp++;
    if ({vend_b, status_b, change_b, credit_b} !== {1'b1, 2'b11, 8'd13, 8'd0}) begin
      n_err++;
      $display("FAIL gen_change: got vend=%0b status=%b change=%0d credit=%0d want 1 11 13 0",
               vend_b, status_b, change_b, credit_b);
    end
  endtask

  task automatic test_random();
    logic [1:0] ca;
    logic [2:0] cb;
    logic       xa, xb;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ca = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cb = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      xa = ($urandom_range(0, 9) == 0);
      xb = ($urandom_range(0, 7) == 0);
      tick(ca, xa, cb, xb);
      n_cmp++;
      if (credit_a !== 8'(ma.credit) || vend_a !== ma.vend || change_a !== 8'(ma.change) ||
          status_a !== 2'(ma.status) || busy_a !== ma.busy) begin
        n_err++;
        $display("FAIL rand_a[%0d]: got c=%0d v=%0b ch=%0d s=%b b=%0b want c=%0d v=%0b ch=%0d s=%0d b=%0b",
                 i, credit_a, vend_a, change_a, status_a, busy_a,
                 ma.credit, ma.vend, ma.change, ma.status, ma.busy);
      end
      n_cmp++;
      if (credit_b !== 8'(mb.credit) || vend_b !== mb.vend || change_b !== 8'(mb.change) ||
          status_b !== 2'(mb.status) || busy_b !== mb.busy) begin
        n_err++;
        $display("FAIL rand_b[%0d]: got c=%0d v=%0b ch=%0d s=%b b=%0b want c=%0d v=%0b ch=%0d s=%0d b=%0b",
                 i, credit_b, vend_b, change_b, status_b, busy_b,
                 mb.credit, mb.vend, mb.change, mb.status, mb.busy);
      end
    end
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    test_reset();
    test_exact_price();
    test_overpay();
    test_refund();
    test_simultaneous();
    test_lockout_reset();
    test_general();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/coin_credit_fsm.md
# coin_credit_fsm

Parametrised coin-credit accumulator and vend controller for the vending machine datapath. It generalises the fixed 5/10-unit, price-25 accumulator to N coin channels with configurable values, price and status-hold time. It adds a cancel/refund path and reports explicit change. It sits between the debounced key/coin pulse generators and the display/dispense logic.

## Interface
Parameters:
- `NUM_COIN`, default 2: number of coin input channels, 1..8.
- `CNT_W`, default 8: width of the credit and change registers. Must hold `PRICE-1 + max(COIN_VAL)`; any larger width is out of scope.
- `COIN_VAL`, default {8'd10, 8'd5}: packed `NUM_COIN` x `CNT_W` coin values, where channel i uses bits [i*CNT_W +: CNT_W]. Every value must be non-zero.
- `PRICE`, default 25: item price in credit units. Must be at least 1.
- `HOLD_CYCLES`, default 100_000_000: number of cycles the vend/refund status is held (2 s at 50 MHz).
- `HOLD_W`, default 27: width of the hold counter; must satisfy 2^HOLD_W > HOLD_CYCLES.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `coin`, in, NUM_COIN: single-cycle coin-accepted pulses, one bit per channel.
- `cancel`, in, 1: single-cycle refund request.
- `credit`, out, CNT_W: current accumulated credit.
- `vend`, out, 1: one-cycle dispense strobe.
- `change`, out, CNT_W: change or refund amount. Valid while `status` ≠ 00.
- `status`, out, 2: 00 idle/collecting, 01 vend exact, 11 vend with change, 10 refund.
- `busy`, out, 1: high in HOLD; coins and cancel are ignored while it is high.

## Operation
- FSM states are COLLECT (the reset state) and HOLD.
- Coin select in COLLECT:
  - If several `coin` bits are high, only the lowest-index channel is accepted that cycle. The others are dropped.
  - Let `sum = credit + COIN_VAL[sel]`, or `sum = credit` when no coin bit is high.
- COLLECT, `cancel`=1 and `sum`>0 (cancel wins over vend):
  - refund `sum`: `change<=sum`, `status<=10`, `credit<=0`, `vend` stays 0, hold counter cleared, go to HOLD.
- COLLECT, `cancel`=1 and `sum`=0: the request is ignored.
- COLLECT, no cancel, `sum`>=PRICE:
  - `vend<=1` for one cycle, `change<=sum-PRICE`, `credit<=0`.
  - `status<=01` if the change is 0, otherwise `11`.
  - Hold counter cleared, go to HOLD.
- COLLECT otherwise: `credit<=sum`.
- HOLD:
  - `busy=1`; `coin` and `cancel` are ignored and the credit stays 0.
  - The counter increments each cycle.
  - When the counter reaches HOLD_CYCLES-1: `status<=00`, `change<=0`, counter cleared, go to COLLECT.
- Arithmetic:
  - `sum` is computed at CNT_W+1 bits. The parameter constraint guarantees it never overflows CNT_W after subtraction.
  - No saturation logic is required.

## Timing
- Reset values: `credit`=0, `vend`=0, `change`=0, `status`=00, `busy`=0, state COLLECT, hold counter 0. Reset is effective immediately and asynchronously, including mid-HOLD.
- All outputs are registered. A coin or cancel sampled at edge t is reflected in the outputs after edge t.
- `vend` is high for exactly one cycle: the first cycle of HOLD.
- `busy` is high for exactly HOLD_CYCLES cycles per vend or refund.
- The first coin accepted after a HOLD is the one sampled on the edge where `busy` is low again.

## Test plan
- Exact price: with defaults and HOLD_CYCLES=10, coins 5,10,10 on separate cycles. Required response: credit 5,15 then `vend` pulse, `status`=01, `change`=0, `busy` for 10 cycles, then `status`=00.
- Overpay: credit 20, then a 10 coin. Required response: `vend`=1, `change`=5, `status`=11, `credit`=0. Both `change` and `status` clear after the hold.
- Refund and cancel collision: credit 15, then `cancel` together with a 5 coin. Required response: `status`=10, `change`=20, no `vend`. A `cancel` at credit 0 has no effect.
- Simultaneous coins: `coin`=2'b11 at credit 0. Required response: credit=5 (channel 0 only).
- Busy lockout and reset mid-hold: coins during HOLD leave `credit`=0 after the hold. Asserting `rst_n`=0 mid-HOLD clears all outputs at once, and the FSM restarts in COLLECT.
- Generalised config: NUM_COIN=3, COIN_VAL={20,10,1}, PRICE=7. Required response: 1+1+1+1+1+1+1 vends exact; a single 20 coin vends with `change`=13.
